// File: rtl/vga_frame_reader_if.sv
// VGA/writer/ZBT signal bundle for the frame reader.
// Latency: none, wires only.
// Backpressure: the writer holds wr_flag until wr_ack; the VGA side is never stalled.
interface vga_frame_reader_if #(
    parameter int MEM_W  = 36,
    parameter int ADDR_W = 19
);
    logic              frame_flag;
    logic              vga_flag;
    logic [MEM_W-1:0]  vga_pixel;
    logic              done_vga;
    logic              wr_flag;
    logic [MEM_W-1:0]  wr_data;
    logic              wr_ack;
    logic              wr_frame_done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we_b;
    logic [MEM_W-1:0]  mem_data_out;
    logic              mem_data_oe;
    logic [MEM_W-1:0]  mem_data_in;

    // Frame reader side.
    modport slave (
        input  frame_flag, vga_flag, wr_flag, wr_data, wr_frame_done, mem_data_in,
        output vga_pixel, done_vga, wr_ack, mem_addr, mem_we_b, mem_data_out, mem_data_oe
    );

    // VGA stage, writer and ZBT model side.
    modport master (
        output frame_flag, vga_flag, wr_flag, wr_data, wr_frame_done, mem_data_in,
        input  vga_pixel, done_vga, wr_ack, mem_addr, mem_we_b, mem_data_out, mem_data_oe
    );
endinterface

// File: rtl/vga_frame_reader.sv
// ZBT port for the VGA path: arbitrates VGA reads vs. one frame writer, double-buffer bank swap.
// Latency: read data returned 2 cycles after grant; write data driven 2 cycles after grant.
// Backpressure: reads always win; a writer holds wr_flag until wr_ack, never stalls the VGA side.
module vga_frame_reader #(
    parameter int MEM_W           = 36,
    parameter int ADDR_W          = 19,
    parameter int WORDS_PER_FRAME = 153600
) (
    input logic              clock,
    input logic              reset,
    vga_frame_reader_if.slave bus
);
    localparam int OFF_W = ADDR_W - 1;
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS_PER_FRAME - 1);

    logic             display_bank;
    logic             swap_pending;
    logic [OFF_W-1:0] rd_ptr;
    logic [OFF_W-1:0] wr_ptr;
    logic [1:0]       rd_v;
    logic [1:0]       wv;
    logic [MEM_W-1:0] wd0;
    logic [MEM_W-1:0] wd1;
    logic [MEM_W-1:0] pixel_hold;
    logic             rd_grant;
    logic             wr_grant;

    function automatic logic [OFF_W-1:0] next_off(input logic [OFF_W-1:0] p);
        return (p == LAST_OFF) ? '0 : p + OFF_W'(1);
    endfunction

    // A vga_flag coincident with frame_flag is not a real request and is dropped.
    assign rd_grant = bus.vga_flag & ~bus.frame_flag;
    assign wr_grant = bus.wr_flag & ~rd_grant;

    // Bus drive: reader addresses the display bank, writer the back bank.
    always_comb begin
        bus.mem_addr = {display_bank, rd_ptr};
        if (wr_grant) begin
            bus.mem_addr = {~display_bank, wr_ptr};
        end
    end

    assign bus.mem_we_b     = ~wr_grant;
    assign bus.wr_ack       = wr_grant;
    assign bus.done_vga     = rd_v[1];
    assign bus.vga_pixel    = rd_v[1] ? bus.mem_data_in : pixel_hold;
    assign bus.mem_data_oe  = wv[1];
    assign bus.mem_data_out = wd1;

    // Access pipelines: track in-flight reads and carry write data to the ZBT data phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_v       <= '0;
            wv         <= '0;
            wd0        <= '0;
            wd1        <= '0;
            pixel_hold <= '0;
        end else begin
            rd_v <= {rd_v[0], rd_grant};
            wv   <= {wv[0], wr_grant};
            wd1  <= wd0;
            if (wr_grant) begin
                wd0 <= bus.wr_data;
            end
            if (rd_v[1]) begin
                pixel_hold <= bus.mem_data_in;
            end
        end
    end

    // Word pointers: advance per grant, wrap at frame end, rewind on frame boundaries.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (bus.frame_flag) begin
                rd_ptr <= '0;
            end else if (rd_grant) begin
                rd_ptr <= next_off(rd_ptr);
            end
            // A write granted alongside wr_frame_done already used the old pointer.
            if (bus.wr_frame_done) begin
                wr_ptr <= '0;
            end else if (wr_grant) begin
                wr_ptr <= next_off(wr_ptr);
            end
        end
    end

    // Bank swap: a finished back frame becomes visible at the next VGA frame start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            display_bank <= 1'b0;
            swap_pending <= 1'b0;
        end else if (bus.frame_flag && (swap_pending || bus.wr_frame_done)) begin
            display_bank <= ~display_bank;
            swap_pending <= 1'b0;
        end else if (bus.wr_frame_done) begin
            swap_pending <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vga_frame_reader.sv
// Self-checking bench for vga_frame_reader: directed table, corner sequences, random vs. model.
// Latency: n/a.
// Backpressure: writer model holds wr_flag until wr_ack.
module tb_vga_frame_reader;
    localparam int MEM_W = 36;
    localparam int ADDR_W = 19;
    localparam int W = 40;
    localparam int BANK_BIT = 1 << (ADDR_W - 1);

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   passed = 0;

    vga_frame_reader_if #(.MEM_W(MEM_W), .ADDR_W(ADDR_W)) bus ();

    vga_frame_reader #(
        .MEM_W(MEM_W), .ADDR_W(ADDR_W), .WORDS_PER_FRAME(W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit vga, wr, ff, wfd;
        logic [35:0] din, wdat;
        logic [18:0] addr;
        bit we_b, ack, done;
        logic [35:0] pix;
        bit oe;
        logic [35:0] dout;
    } vec_t;

    vec_t vt[19];

    // Behavioural model state
    int m_bank, m_pend, m_rd, m_wr, cyc;
    logic [35:0] m_hold;
    bit rd_due[int];
    logic [35:0] wr_due[int];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        else passed++;
    endtask

    task automatic drive(input bit vga, input bit wr, input bit ff, input bit wfd,
                         input logic [35:0] din, input logic [35:0] wdat);
        @(negedge clock);
        bus.vga_flag = vga;
        bus.wr_flag = wr;
        bus.frame_flag = ff;
        bus.wr_frame_done = wfd;
        bus.mem_data_in = din;
        bus.wr_data = wdat;
        #2;
    endtask

    task automatic model_clear();
        m_bank = 0; m_pend = 0; m_rd = 0; m_wr = 0; cyc = 0;
        m_hold = '0;
        rd_due.delete();
        wr_due.delete();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.vga_flag = 0; bus.wr_flag = 0; bus.frame_flag = 0; bus.wr_frame_done = 0;
        bus.mem_data_in = '0; bus.wr_data = '0;
        #2;
        chk("rst_done", bus.done_vga, 0);
        chk("rst_pix", bus.vga_pixel, 0);
        chk("rst_oe", bus.mem_data_oe, 0);
        chk("rst_we_b", bus.mem_we_b, 1);
        chk("rst_ack", bus.wr_ack, 0);
        chk("rst_addr", bus.mem_addr, 0);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
    endtask

    // One model cycle: predict outputs from current inputs, compare, advance model.
    task automatic model_step(input bit vga, input bit wr, input bit ff, input bit wfd,
                              input logic [35:0] din, input logic [35:0] wdat);
        bit rg, wg, edone, eoe;
        int eaddr;
        logic [35:0] epix;
        drive(vga, wr, ff, wfd, din, wdat);
        rg = vga && !ff;
        wg = wr && !rg;
        eaddr = wg ? ((m_bank ? 0 : BANK_BIT) + m_wr) : ((m_bank ? BANK_BIT : 0) + m_rd);
        edone = rd_due.exists(cyc);
        eoe = wr_due.exists(cyc);
        epix = edone ? din : m_hold;
        chk("rnd_addr", bus.mem_addr, eaddr);
        chk("rnd_we_b", bus.mem_we_b, !wg);
        chk("rnd_ack", bus.wr_ack, wg);
        chk("rnd_done", bus.done_vga, edone);
        chk("rnd_pix", bus.vga_pixel, epix);
        chk("rnd_oe", bus.mem_data_oe, eoe);
        if (eoe) chk("rnd_dout", bus.mem_data_out, wr_due[cyc]);
        if (edone) m_hold = din;
        if (edone) rd_due.delete(cyc);
        if (eoe) wr_due.delete(cyc);
        if (rg) rd_due[cyc + 2] = 1'b1;
        if (wg) wr_due[cyc + 2] = wdat;
        m_rd = ff ? 0 : (rg ? (m_rd + 1) % W : m_rd);
        m_wr = wfd ? 0 : (wg ? (m_wr + 1) % W : m_wr);
        if (ff && (m_pend || wfd)) begin
            m_bank = 1 - m_bank;
            m_pend = 0;
        end else if (wfd) begin
            m_pend = 1;
        end
        cyc++;
    endtask

    initial begin
        bit prev_vga, wr_pend, ff, wfd, vga;
        logic [35:0] wdat, din;

        // vga, wr, ff, wfd, din, wdat, addr, we_b, ack, done, pix, oe, dout
        vt[0]  = '{0,0,0,0, 36'h0, 36'h0, 19'h00000, 1,0,0, 36'h0, 0, 36'h0};
        vt[1]  = '{1,0,0,0, 36'h0, 36'h0, 19'h00000, 1,0,0, 36'h0, 0, 36'h0};
        vt[2]  = '{0,0,0,0, 36'h0, 36'h0, 19'h00001, 1,0,0, 36'h0, 0, 36'h0};
        vt[3]  = '{0,0,0,0, 36'hABCDE1234, 36'h0, 19'h00001, 1,0,1, 36'hABCDE1234, 0, 36'h0};
        vt[4]  = '{0,0,0,0, 36'h123456789, 36'h0, 19'h00001, 1,0,0, 36'hABCDE1234, 0, 36'h0};
        vt[5]  = '{1,1,0,0, 36'h0, 36'h0AAAA5555, 19'h00001, 1,0,0, 36'hABCDE1234, 0, 36'h0};
        vt[6]  = '{0,1,0,0, 36'h0, 36'h0AAAA5555, 19'h40000, 0,1,0, 36'hABCDE1234, 0, 36'h0};
        vt[7]  = '{0,0,0,0, 36'h0F0F0F0F0, 36'h0, 19'h00002, 1,0,1, 36'h0F0F0F0F0, 0, 36'h0};
        vt[8]  = '{0,0,0,0, 36'h0, 36'h0, 19'h00002, 1,0,0, 36'h0F0F0F0F0, 1, 36'h0AAAA5555};
        vt[9]  = '{0,0,0,1, 36'h0, 36'h0, 19'h00002, 1,0,0, 36'h0F0F0F0F0, 0, 36'h0};
        vt[10] = '{0,0,1,0, 36'h0, 36'h0, 19'h00002, 1,0,0, 36'h0F0F0F0F0, 0, 36'h0};
        vt[11] = '{1,0,0,0, 36'h0, 36'h0, 19'h40000, 1,0,0, 36'h0F0F0F0F0, 0, 36'h0};
        vt[12] = '{0,1,0,0, 36'h0, 36'h5, 19'h00000, 0,1,0, 36'h0F0F0F0F0, 0, 36'h0};
        vt[13] = '{0,0,0,0, 36'h777, 36'h0, 19'h40001, 1,0,1, 36'h777, 0, 36'h0};
        vt[14] = '{0,0,0,0, 36'h0, 36'h0, 19'h40001, 1,0,0, 36'h777, 1, 36'h5};
        vt[15] = '{0,0,1,0, 36'h0, 36'h0, 19'h40001, 1,0,0, 36'h777, 0, 36'h0};
        vt[16] = '{0,0,0,0, 36'h0, 36'h0, 19'h40000, 1,0,0, 36'h777, 0, 36'h0};
        vt[17] = '{0,0,1,1, 36'h0, 36'h0, 19'h40000, 1,0,0, 36'h777, 0, 36'h0};
        vt[18] = '{0,0,0,0, 36'h0, 36'h0, 19'h00000, 1,0,0, 36'h777, 0, 36'h0};

        bus.vga_flag = 0; bus.wr_flag = 0; bus.frame_flag = 0; bus.wr_frame_done = 0;
        bus.mem_data_in = '0; bus.wr_data = '0;
        repeat (2) @(posedge clock);
        do_reset();

        // Directed table
        for (int i = 0; i < 19; i++) begin
            drive(vt[i].vga, vt[i].wr, vt[i].ff, vt[i].wfd, vt[i].din, vt[i].wdat);
            chk($sformatf("tbl%0d_addr", i), bus.mem_addr, vt[i].addr);
            chk($sformatf("tbl%0d_we_b", i), bus.mem_we_b, vt[i].we_b);
            chk($sformatf("tbl%0d_ack", i), bus.wr_ack, vt[i].ack);
            chk($sformatf("tbl%0d_done", i), bus.done_vga, vt[i].done);
            chk($sformatf("tbl%0d_pix", i), bus.vga_pixel, vt[i].pix);
            chk($sformatf("tbl%0d_oe", i), bus.mem_data_oe, vt[i].oe);
            if (vt[i].oe) chk($sformatf("tbl%0d_dout", i), bus.mem_data_out, vt[i].dout);
        end

        // Read pointer wrap: read W+1 must address word 0 again
        do_reset();
        for (int i = 0; i <= W; i++) begin
            drive(1, 0, 0, 0, '0, '0);
            chk($sformatf("wrap%0d_addr", i), bus.mem_addr, i % W);
            drive(0, 0, 0, 0, '0, '0);
        end

        // Reset while a write and a read are in flight
        do_reset();
        drive(0, 1, 0, 0, '0, 36'hDEADBEEF1);
        chk("mid_wr_ack", bus.wr_ack, 1);
        drive(1, 0, 0, 0, '0, '0);
        chk("mid_rd_addr", bus.mem_addr, 0);
        @(negedge clock);
        bus.vga_flag = 0;
        bus.mem_data_in = 36'h55555AAAA;
        reset = 1'b1;
        #2;
        chk("mid_rst_oe", bus.mem_data_oe, 0);
        chk("mid_rst_done", bus.done_vga, 0);
        chk("mid_rst_pix", bus.vga_pixel, 0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 36'h55555AAAA, '0);
            chk($sformatf("post_rst%0d_done", i), bus.done_vga, 0);
            chk($sformatf("post_rst%0d_oe", i), bus.mem_data_oe, 0);
            chk($sformatf("post_rst%0d_pix", i), bus.vga_pixel, 0);
        end

        // Randomized traffic against the model
        do_reset();
        prev_vga = 0;
        wr_pend = 0;
        wdat = '0;
        for (int n = 0; n < 3000; n++) begin
            ff = ($urandom_range(0, 49) == 0);
            wfd = ($urandom_range(0, 39) == 0);
            vga = !ff && !prev_vga && ($urandom_range(0, 2) == 0);
            if (!wr_pend && ($urandom_range(0, 1) == 1)) begin
                wr_pend = 1;
                wdat = {4'($urandom), 32'($urandom)};
            end
            din = {4'($urandom), 32'($urandom)};
            model_step(vga, wr_pend, ff, wfd, din, wdat);
            if (wr_pend && !vga) wr_pend = 0;
            prev_vga = vga;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Memory-side port for the VGA output path: turns the VGA stage's read requests into ZBT SRAM reads and returns the pixel pair after exactly 2 cycles.
- Shares the ZBT bus with one frame-writer client (camera/render path) and manages double-buffer bank swapping at frame boundaries.
- Sits between the ZBT pins and the VGA output stage; uses that stage's vga_flag/vga_pixel/done_vga protocol.

Parameters:
- MEM_W, 36, ZBT word width; one word = two 18-bit pixels, upper half first.
- ADDR_W, 19, ZBT address width; MSB is bank select, low ADDR_W-1 bits are word offset.
- WORDS_PER_FRAME, 153600, words per frame (640*480/2); offset wraps after WORDS_PER_FRAME-1.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- frame_flag  in  1  one-cycle pulse at start of VGA frame.
- vga_flag  in  1  read request from VGA stage; single-cycle, never asserted in two consecutive cycles.
- vga_pixel  out  MEM_W  returned word.
- done_vga  out  1  one-cycle pulse when vga_pixel carries new read data.
- wr_flag  in  1  write request; held until wr_ack.
- wr_data  in  MEM_W  write word; stable while wr_flag is high.
- wr_ack  out  1  combinational; write accepted this cycle.
- wr_frame_done  in  1  one-cycle pulse; writer finished a frame.
- mem_addr  out  ADDR_W  ZBT address, combinational.
- mem_we_b  out  1  ZBT write enable, active low.
- mem_data_out  out  MEM_W  ZBT write data.
- mem_data_oe  out  1  tristate enable for mem_data_out.
- mem_data_in  in  MEM_W  ZBT read data bus.

Behaviour:
- Registers: display_bank, swap_pending, rd_ptr, wr_ptr, 2-stage read pipe (rd_v[1:0]), 2-stage write pipe (wv[1:0] plus data), pixel_hold.
- Reset (async) clears all registers to 0. At reset: done_vga=0, vga_pixel=0, mem_data_oe=0, mem_we_b=1, wr_ack=0, mem_addr=0.
- Arbitration, cycle t:
  - Read has priority. If vga_flag: mem_addr={display_bank,rd_ptr}, mem_we_b=1, wr_ack=0, rd_ptr advances.
  - Else if wr_flag: mem_addr={~display_bank,wr_ptr}, mem_we_b=0, wr_ack=1, wr_ptr advances.
  - Else mem_we_b=1 and mem_addr holds {display_bank,rd_ptr}.
- Pointer wrap: each pointer goes from WORDS_PER_FRAME-1 to 0.
- Read latency:
  - A grant at t sets rd_v[0] at t+1 and rd_v[1] at t+2.
  - In t+2: done_vga=1 and vga_pixel=mem_data_in (combinational). pixel_hold captures mem_data_in at the end of t+2.
  - Otherwise vga_pixel=pixel_hold.
- Write latency:
  - A write granted at t registers wr_data at the end of t.
  - In t+2: mem_data_out holds that word and mem_data_oe=1. mem_data_oe=0 otherwise.
- Bus turnaround: a read granted at t+1 or t+2 following a write at t is legal; ZBT is no-turnaround. There are no stall cycles.
- frame_flag: rd_ptr<=0. Any vga_flag in the same cycle is ignored; the VGA stage never issues one.
- wr_frame_done: wr_ptr<=0 and swap_pending<=1. A write granted in the same cycle is still performed at the old wr_ptr.
- Bank swap:
  - On frame_flag with (swap_pending | wr_frame_done), display_bank toggles and swap_pending<=0.
  - Reads and writes already in flight complete at their latched addresses.
- A second wr_frame_done while swap_pending=1 keeps pending=1. The writer rewrites the same back bank; no error.
- Writes may complete partially if frame_flag swaps banks before wr_frame_done. This is the writer's problem; no checking here.
- Reset mid-operation: in-flight reads and writes are dropped. No done_vga or mem_data_oe follows reset.

Test Plan:
- Reset, then vga_flag at cycle 1 with mem_data_in=36'hABCDE1234 in cycle 3 -> mem_addr=0 in cycle 1; done_vga=1 and vga_pixel=36'hABCDE1234 in cycle 3 only; vga_pixel holds after.
- wr_flag held with vga_flag pulsed in the same cycle -> wr_ack=0 that cycle and mem_addr={0,rd_ptr}; write granted next cycle at {1,0}, mem_we_b=0; mem_data_oe=1 two cycles later carrying wr_data.
- 153600 reads -> rd_ptr wraps to 0; 153601st read addresses word 0.
- wr_frame_done, then frame_flag 10 cycles later -> display_bank=1, swap_pending=0; next read addr 19'h40000, next write addr 19'h00000.
- frame_flag with no pending swap -> display_bank unchanged, rd_ptr=0; wr_frame_done coincident with frame_flag -> swap in that cycle.
- Assert reset in the cycle after a read grant -> no done_vga pulse, vga_pixel=0, mem_data_oe stays 0.
